gen3_lane_scrambler: RTL and testbench

Per-lane 128b/130b scrambling stage for Gen3+ transmit. It takes 32-bit block words from the block framer and XORs them with the 32-bit keystream from the lane LFSR, following the ordered-set bypass rules. It drives advance and reseed strobes back to the LFSR, then registers scrambled words, with sync header and block markers, toward the gearbox. One block is a 2-bit sync header plus 4 words of 32 bits.

---
 rtl/gen3_lane_scrambler.sv | 144 ++++++++++++++
 tb/tb_gen3_lane_scrambler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen3_lane_scrambler.sv
// gen3_lane_scrambler: per-lane 128b/130b transmit scrambling stage.
// Words from the block framer are XORed with the lane LFSR keystream
// according to the block class latched at the sync header. The stage also
// drives the LFSR advance/reseed strobes and registers the result toward
// the gearbox with one cycle of latency.
//
// Block tracking state:
//   state                  | meaning
//   in_block=0             | idle, waiting for a word carrying in_block_start
//   in_block=1, word_idx=n | inside a block, word n is the next expected word
//   blk_class              | DATA / TS / SKP / EIEOS / EIOS, latched at word 0

module gen3_lane_scrambler (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_block_start,
    input  logic [1:0]  in_sync_hdr,
    input  logic [1:0]  in_os_type,
    input  logic [31:0] ks_data,
    output logic        ks_advance,
    output logic        ks_seed_load,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [1:0]  out_sync_hdr,
    output logic        out_block_start,
    output logic        err_framing
);

    typedef enum logic [2:0] {
        CLS_DATA  = 3'd0,
        CLS_TS    = 3'd1,
        CLS_SKP   = 3'd2,
        CLS_EIEOS = 3'd3,
        CLS_EIOS  = 3'd4
    } blk_class_t;

    logic [1:0]  word_idx;
    logic        in_block;
    blk_class_t  blk_class;

    logic [1:0]  nxt_word_idx;
    logic        nxt_in_block;
    blk_class_t  nxt_blk_class;

    logic        accept;
    logic        drop;
    logic        hdr_bad;
    blk_class_t  hdr_class;
    blk_class_t  cur_class;
    logic [1:0]  cur_idx;
    logic [31:0] mask;
    logic [31:0] scrambled;
    logic        err_now;

    assign accept  = in_valid & (in_block_start | in_block);
    assign drop    = in_valid & ~in_block_start & ~in_block;
    // A start word uses the class and index implied by its own header.
    assign cur_class = in_block_start ? hdr_class : blk_class;
    assign cur_idx   = in_block_start ? 2'd0 : word_idx;

    // Decode the sync header and ordered-set type into a block class.
    always_comb begin
        hdr_bad   = 1'b0;
        hdr_class = CLS_DATA;
        case (in_sync_hdr)
            2'b10: hdr_class = CLS_DATA;
            2'b01: begin
                case (in_os_type)
                    2'd0:    hdr_class = CLS_TS;
                    2'd1:    hdr_class = CLS_SKP;
                    2'd2:    hdr_class = CLS_EIEOS;
                    default: hdr_class = CLS_EIOS;
                endcase
            end
            default: begin
                hdr_bad   = 1'b1;
                hdr_class = CLS_DATA;
            end
        endcase
    end

    // Block tracking state register.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx  <= 2'd0;
            in_block  <= 1'b0;
            blk_class <= CLS_DATA;
        end else begin
            word_idx  <= nxt_word_idx;
            in_block  <= nxt_in_block;
            blk_class <= nxt_blk_class;
        end
    end

    // Next-state: advance the word index on every accepted word; word 3 closes the block.
    always_comb begin
        nxt_word_idx  = word_idx;
        nxt_in_block  = in_block;
        nxt_blk_class = blk_class;
        if (accept) begin
            nxt_blk_class = cur_class;
            nxt_word_idx  = cur_idx + 2'd1;
            nxt_in_block  = (cur_idx != 2'd3);
        end
    end

    // Output logic: keystream mask, LFSR strobes and framing error detection.
    always_comb begin
        mask = 32'h0000_0000;
        case (cur_class)
            CLS_DATA: mask = 32'hFFFF_FFFF;
            CLS_TS:   mask = (cur_idx == 2'd0) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
            default:  mask = 32'h0000_0000;
        endcase
        scrambled    = in_data ^ (ks_data & mask);
        ks_advance   = reset_n & accept & (cur_class != CLS_SKP);
        ks_seed_load = reset_n & accept & (cur_class == CLS_EIEOS) & (cur_idx == 2'd3);
        err_now      = drop | (accept & in_block_start & (in_block | hdr_bad));
    end

    // Output register toward the gearbox; data and header hold when idle.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid       <= 1'b0;
            out_data        <= 32'h0000_0000;
            out_sync_hdr    <= 2'b00;
            out_block_start <= 1'b0;
            err_framing     <= 1'b0;
        end else begin
            out_valid       <= accept;
            out_block_start <= accept & in_block_start;
            err_framing     <= err_now;
            if (accept) begin
                out_data <= scrambled;
            end
            if (accept && in_block_start) begin
                out_sync_hdr <= in_sync_hdr;
            end
        end
    end

endmodule

// File: tb/tb_gen3_lane_scrambler.sv
// Bench for gen3_lane_scrambler: directed scenarios plus random traffic,
// checked against a block-level reference model through a scoreboard.

module tb_gen3_lane_scrambler;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_block_start = 1'b0;
    logic [1:0]  in_sync_hdr = 2'b00;
    logic [1:0]  in_os_type = 2'b00;
    logic [31:0] ks_data = '0;
    logic        ks_advance;
    logic        ks_seed_load;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sync_hdr;
    logic        out_block_start;
    logic        err_framing;

    gen3_lane_scrambler dut (
        .pclk(pclk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_block_start(in_block_start), .in_sync_hdr(in_sync_hdr), .in_os_type(in_os_type),
        .ks_data(ks_data), .ks_advance(ks_advance), .ks_seed_load(ks_seed_load),
        .out_valid(out_valid), .out_data(out_data), .out_sync_hdr(out_sync_hdr),
        .out_block_start(out_block_start), .err_framing(err_framing)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        bs;
        logic [1:0]  hdr;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: class 0=DATA 1=TS 2=SKP 3=EIEOS 4=EIOS
    bit m_in_block = 1'b0;
    int m_pos = 0;
    int m_cls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int class_of(input logic [1:0] hdr, input logic [1:0] os);
        if (hdr == 2'b01) return 1 + int'(os);
        return 0;
    endfunction

    function automatic logic [31:0] ref_word(input int cls, input int pos,
                                             input logic [31:0] d, input logic [31:0] ks);
        case (cls)
            0: return d ^ ks;
            1: return (pos == 0) ? {d[31:8] ^ ks[31:8], d[7:0]} : d ^ ks;
            default: return d;
        endcase
    endfunction

    // One input cycle: drive, update the model, check strobes, queue expectations.
    task automatic drive(input logic v, input logic bs, input logic [1:0] hdr,
                         input logic [1:0] os, input logic [31:0] d, input logic [31:0] ks);
        bit accepted, dropped, err, adv, seed;
        int cls, pos;
        logic [31:0] w;
        @(posedge pclk);
        #1;
        in_valid = v; in_block_start = bs; in_sync_hdr = hdr; in_os_type = os;
        in_data = d; ks_data = ks;
        accepted = v && (bs || m_in_block);
        dropped  = v && !bs && !m_in_block;
        err = dropped || (v && bs && (m_in_block || hdr == 2'b00 || hdr == 2'b11));
        cls = bs ? class_of(hdr, os) : m_cls;
        pos = bs ? 0 : m_pos;
        adv  = accepted && (cls != 2);
        seed = accepted && (cls == 3) && (pos == 3);
        w = ref_word(cls, pos, d, ks);
        #1;
        check("ks_advance", 32'(ks_advance), 32'(adv));
        check("ks_seed_load", 32'(ks_seed_load), 32'(seed));
        if (accepted) begin
            exp_q.push_back('{cyc + 1, w, bs, hdr});
            m_cls = cls;
            m_pos = pos + 1;
            m_in_block = (pos < 3);
        end
        if (err) err_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, $urandom);
    endtask

    task automatic send_word(input int idx, input logic [1:0] hdr, input logic [1:0] os,
                             input logic [31:0] d, input logic [31:0] ks);
        drive(1'b1, idx == 0, hdr, os, d, ks);
    endtask

    task automatic send_block(input logic [1:0] hdr, input logic [1:0] os,
                              input logic [31:0] d, input logic [31:0] ks);
        for (int i = 0; i < 4; i++) send_word(i, hdr, os, d, ks);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_sync_hdr"}, 32'(out_sync_hdr), 32'h0);
        check({tag, "_out_block_start"}, 32'(out_block_start), 32'h0);
        check({tag, "_err_framing"}, 32'(err_framing), 32'h0);
    endtask

    // Asynchronous reset in the middle of a block.
    task automatic reset_mid_block();
        @(posedge pclk);
        #1;
        in_valid = 1'b0; in_block_start = 1'b0;
        #4;
        reset_n = 1'b0;
        exp_q.delete();
        err_q.delete();
        m_in_block = 1'b0;
        m_pos = 0;
        #1;
        check_outputs_zero("reset_async");
        in_valid = 1'b1; in_block_start = 1'b1; in_sync_hdr = 2'b01; in_os_type = 2'd2;
        #1;
        check("reset_ks_advance", 32'(ks_advance), 32'h0);
        check("reset_ks_seed_load", 32'(ks_seed_load), 32'h0);
        in_valid = 1'b0; in_block_start = 1'b0;
        repeat (2) @(posedge pclk);
        #2;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: compares registered outputs 3 time units after each edge.
    initial begin
        bit exp_err;
        exp_t e;
        forever begin
            @(posedge pclk);
            #3;
            if (reset_n) begin
                exp_err = 1'b0;
                if (err_q.size() > 0 && err_q[0] <= cyc) begin
                    exp_err = (err_q[0] == cyc);
                    void'(err_q.pop_front());
                end
                check("err_framing", 32'(err_framing), 32'(exp_err));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 32'(out_valid), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_latency", 32'(cyc), 32'(e.due));
                        check("out_data", out_data, e.data);
                        check("out_block_start", 32'(out_block_start), 32'(e.bs));
                        if (e.bs) check("out_sync_hdr", 32'(out_sync_hdr), 32'(e.hdr));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("missing_out_valid", 32'(out_valid), 32'h1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic bs, v;
        logic [1:0] hdr;
        int r;

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        check_outputs_zero("in_reset");
        in_valid = 1'b1; in_block_start = 1'b1; in_sync_hdr = 2'b10;
        #1;
        check("in_reset_ks_advance", 32'(ks_advance), 32'h0);
        in_valid = 1'b0; in_block_start = 1'b0;
        @(posedge pclk);
        #2;
        reset_n = 1'b1;
        @(posedge pclk);
        #2;
        check_outputs_zero("after_reset");

        // DATA block: 1234_5678 ^ FFFF_0000 = EDCB_5678
        send_block(2'b10, 2'd0, 32'h1234_5678, 32'hFFFF_0000);
        idle(2);

        // TS1 block: symbol 0 bypassed on word 0
        send_word(0, 2'b01, 2'd0, 32'h0000_001E, 32'hFFFF_FFFF);
        for (int i = 1; i < 4; i++) send_word(i, 2'b01, 2'd0, $urandom, 32'hFFFF_FFFF);
        idle(1);

        // SKP then EIEOS back to back, then EIOS
        send_block(2'b01, 2'd1, 32'hAAAA_5555, 32'h1357_9BDF);
        send_block(2'b01, 2'd2, 32'hFF00_FF00, 32'h2468_ACE0);
        send_block(2'b01, 2'd3, 32'h6666_7777, 32'hDEAD_BEEF);
        idle(1);

        // Framing: stray word, bad header, early start at word_idx = 2
        drive(1'b1, 1'b0, 2'b10, 2'd0, 32'hBAD0_0001, 32'hFFFF_FFFF);
        idle(1);
        send_block(2'b00, 2'd0, 32'h0F0F_0F0F, 32'h1111_2222);
        send_block(2'b11, 2'd0, 32'h0F0F_0F0F, 32'h3333_4444);
        send_word(0, 2'b10, 2'd0, 32'h0101_0101, $urandom);
        send_word(1, 2'b10, 2'd0, 32'h0202_0202, $urandom);
        send_block(2'b01, 2'd0, 32'h0303_0303, $urandom);
        idle(2);

        // Reset mid-block, then a word without start is dropped
        send_word(0, 2'b10, 2'd0, 32'h5555_0000, $urandom);
        send_word(1, 2'b10, 2'd0, 32'h5555_0001, $urandom);
        reset_mid_block();
        drive(1'b1, 1'b0, 2'b10, 2'd0, 32'h5555_0002, $urandom);
        idle(2);

        // Gaps inside a block, then back-to-back blocks
        send_word(0, 2'b10, 2'd0, 32'hC0DE_0000, $urandom);
        send_word(1, 2'b10, 2'd0, 32'hC0DE_0001, $urandom);
        idle(3);
        send_word(2, 2'b10, 2'd0, 32'hC0DE_0002, $urandom);
        send_word(3, 2'b10, 2'd0, 32'hC0DE_0003, $urandom);
        send_block(2'b01, 2'd0, 32'hC0DE_0004, $urandom);
        send_block(2'b10, 2'd0, 32'hC0DE_0005, $urandom);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            v = (r < 80);
            if (m_in_block) bs = ($urandom_range(0, 15) == 0);
            else            bs = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 19);
            hdr = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 11) ? 2'b10 : 2'b01;
            drive(v, bs, hdr, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        idle(4);

        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        check("err_queue_drained", 32'(err_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
